pingpong_ram_ctrl: RTL and testbench
====================================

Name: pingpong_ram_ctrl

Overview:
- Single-clock ping-pong controller that sequences a width-converting dual-port RAM (write width WIDTH_WR, read width WIDTH_RD) as two half-depth banks.
- A valid/ready input stream fills one bank while the other bank is drained to a valid/ready output stream.
- Bank ownership, RAM addresses and RAM read latency are all handled here. The RAM instance sits outside this block, with both of its clocks tied to clk.

Parameters:
- WIDTH_WR, 8, RAM write/input word width.
- DEPTH_WR, 128, RAM depth in write words; must be even and a power of 2.
- WIDTH_RD, 16, RAM read/output word width.
- DEPTH_RD, 64, RAM depth in read words; constraint WIDTH_WR*DEPTH_WR == WIDTH_RD*DEPTH_RD.

Ports:
- clk  in  1  clock, for the block and both RAM ports.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid&&s_ready.
- s_data  in  WIDTH_WR  input word.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts.
- m_data  out  WIDTH_RD  output word.
- ram_wr_en  out  1  RAM write enable.
- ram_wr_addr  out  $clog2(DEPTH_WR)  RAM write address.
- ram_wr_data  out  WIDTH_WR  RAM write data.
- ram_rd_addr  out  $clog2(DEPTH_RD)  RAM read address.
- ram_rd_data  in  WIDTH_RD  RAM registered read data, valid 1 cycle after the address is sampled.

Behaviour:
- Reset (async, rst_n=0):
  - wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, bank_full=2'b00, output buffer empty.
  - Outputs: s_ready=1, m_valid=0, m_data=0, ram_wr_en=0, ram_wr_addr=0, ram_rd_addr=0.
- Write side:
  - s_ready = !bank_full[wr_bank].
  - ram_wr_en = s_valid&&s_ready (combinational); ram_wr_addr = {wr_bank, wr_cnt}; ram_wr_data = s_data.
  - On each accept wr_cnt++.
  - When wr_cnt == DEPTH_WR/2-1 is accepted: set bank_full[wr_bank], toggle wr_bank, wr_cnt=0.
- Read side:
  - ram_rd_addr = {rd_bank, rd_cnt}.
  - A read is issued in a cycle when bank_full[rd_bank]==1 and (buffer count + in-flight reads) < 2; issue means rd_cnt++ at that edge.
  - One cycle later, ram_rd_data is pushed into a 2-entry output FIFO.
  - When the last address (rd_cnt == DEPTH_RD/2-1) is issued: clear bank_full[rd_bank], toggle rd_bank, rd_cnt=0.
  - The bank is released at the issue edge because the RAM has already sampled the address.
- Output: m_valid = FIFO non-empty; m_data = FIFO head; pop on m_valid&&m_ready.
  - Sustained 1 word/cycle when m_ready is held high.
  - m_data is held stable while m_valid&&!m_ready.
- Latency: the first output word of a bank appears 2 cycles after the edge that fills that bank.
- Simultaneous events:
  - Setting bank_full on one bank and clearing it on the other in the same cycle is legal; both take effect.
  - Setting and clearing the same bank in one cycle is impossible by construction. Assert this in simulation.
- Both banks full: s_ready=0 until the reader issues the last address of rd_bank.
- Word ordering is big-endian, and the RAM performs it. With default parameters, bytes A then B written to addresses 2k and 2k+1 read back as {A,B}.
- Reset mid-operation: all state is discarded immediately, partial bank contents are abandoned, and no RAM write occurs while rst_n=0.

Optional Feature:
- Macro: PINGPONG_STATUS_EN.
- Defined:
  - Adds output port bank_full (2 bits, the live flags).
  - Adds output port swap_cnt (16 bits). It increments on every read-bank release, wraps at 16'hFFFF->0, and resets to 0.
- Undefined: neither port exists and the logic is identical otherwise.

Test Plan:
- Default parameters: after reset, stream bytes 0x00..0x3F with m_ready=1 -> 32 words 0x0001,0x0203,...,0x3E3F; first m_valid 2 cycles after byte 0x3F is accepted.
- Continuous stream of 256 bytes with m_ready=1 -> no s_ready deassertion after the first bank; 128 output words in order; banks alternate.
- m_ready=0, write 128 bytes -> s_ready drops to 0 after byte 127, both bank_full flags set. Then raise m_ready -> 64 words out, and s_ready returns 1 the cycle after the 32nd address of bank 0 is issued.
- Random m_ready backpressure over 1024 bytes -> no loss or duplication; m_data held stable during stalls; FIFO never exceeds 2 entries.
- Assert rst_n=0 mid-bank (after 20 bytes) -> m_valid=0, s_ready=1, ram_wr_en=0 immediately. A fresh 64-byte stream then reads back correctly from bank 0.
- With PINGPONG_STATUS_EN defined, run 4 full banks -> swap_cnt=4; bank_full tracks the expected 2'b01/2'b11/2'b10 sequence.

Source files
------------

// File: rtl/pingpong_ram_ctrl.sv
// pingpong_ram_ctrl: single-clock ping-pong sequencer for a width-converting
// dual-port RAM split into two half-depth banks. An input stream fills one
// bank while the other bank is read out through a 2-entry output buffer that
// absorbs the one-cycle registered RAM read latency.
// Optional build macro PINGPONG_STATUS_EN exposes the live bank_full flags
// and a 16-bit count of read-bank releases (swap_cnt).
module pingpong_ram_ctrl #(
   parameter int WIDTH_WR = 8,
   parameter int DEPTH_WR = 128,
   parameter int WIDTH_RD = 16,
   parameter int DEPTH_RD = 64
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [WIDTH_WR-1:0]         s_data,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [WIDTH_RD-1:0]         m_data,
   output logic                        ram_wr_en,
   output logic [$clog2(DEPTH_WR)-1:0] ram_wr_addr,
   output logic [WIDTH_WR-1:0]         ram_wr_data,
   output logic [$clog2(DEPTH_RD)-1:0] ram_rd_addr,
   input  logic [WIDTH_RD-1:0]         ram_rd_data
`ifdef PINGPONG_STATUS_EN
   ,
   output logic [1:0]                  bank_full,
   output logic [15:0]                 swap_cnt
`endif
);

   localparam int WC_W = $clog2(DEPTH_WR) - 1;
   localparam int RC_W = $clog2(DEPTH_RD) - 1;
   localparam logic [WC_W-1:0] WC_LAST = WC_W'(DEPTH_WR / 2 - 1);
   localparam logic [RC_W-1:0] RC_LAST = RC_W'(DEPTH_RD / 2 - 1);

   logic                wr_bank_q, wr_bank_d;
   logic                rd_bank_q, rd_bank_d;
   logic [WC_W-1:0]     wr_cnt_q, wr_cnt_d;
   logic [RC_W-1:0]     rd_cnt_q, rd_cnt_d;
   logic [1:0]          bank_full_q, bank_full_d;
   logic                inflight_q, inflight_d;
   logic [1:0]          fifo_cnt_q, fifo_cnt_d;
   logic                fifo_rptr_q, fifo_rptr_d;
   logic                fifo_wptr_q, fifo_wptr_d;
   logic [WIDTH_RD-1:0] fifo_mem_q [2];
   logic [WIDTH_RD-1:0] fifo_mem_d [2];

   logic       wr_acc, wr_last, rd_issue, rd_last, pop;
   logic [1:0] occ, set_full, clr_full;

   // Write side: a bank accepts data until it is marked full. Writes are
   // suppressed while reset is held so nothing reaches the RAM.
   assign s_ready     = !bank_full_q[wr_bank_q];
   assign wr_acc      = s_valid && s_ready && rst_n;
   assign wr_last     = (wr_cnt_q == WC_LAST);
   assign ram_wr_en   = wr_acc;
   assign ram_wr_addr = {wr_bank_q, wr_cnt_q};
   assign ram_wr_data = s_data;

   // Read side: occupancy counts buffered words plus the read in flight,
   // minus a word leaving this cycle, so a held m_ready streams every cycle.
   assign pop         = m_valid && m_ready;
   assign occ         = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
   assign rd_issue    = bank_full_q[rd_bank_q] && (occ < 2'd2);
   assign rd_last     = (rd_cnt_q == RC_LAST);
   assign ram_rd_addr = {rd_bank_q, rd_cnt_q};
   assign m_valid     = (fifo_cnt_q != 2'd0);
   assign m_data      = fifo_mem_q[fifo_rptr_q];

   // A bank is released as soon as its last address is issued: the RAM has
   // already sampled it, so the writer may reuse the bank on the next edge.
   assign set_full[0] = wr_acc && wr_last && !wr_bank_q;
   assign set_full[1] = wr_acc && wr_last &&  wr_bank_q;
   assign clr_full[0] = rd_issue && rd_last && !rd_bank_q;
   assign clr_full[1] = rd_issue && rd_last &&  rd_bank_q;

   // Next-state for bank ownership, counters and the output buffer.
   always_comb begin
      wr_bank_d   = wr_bank_q;
      wr_cnt_d    = wr_cnt_q;
      rd_bank_d   = rd_bank_q;
      rd_cnt_d    = rd_cnt_q;
      bank_full_d = (bank_full_q | set_full) & ~clr_full;
      inflight_d  = rd_issue;
      fifo_mem_d  = fifo_mem_q;
      fifo_wptr_d = fifo_wptr_q ^ inflight_q;
      fifo_rptr_d = fifo_rptr_q ^ pop;
      fifo_cnt_d  = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
      if (wr_acc) begin
         wr_cnt_d = wr_cnt_q + 1'b1;
         if (wr_last) begin
            wr_bank_d = !wr_bank_q;
            wr_cnt_d  = '0;
         end
      end
      if (rd_issue) begin
         rd_cnt_d = rd_cnt_q + 1'b1;
         if (rd_last) begin
            rd_bank_d = !rd_bank_q;
            rd_cnt_d  = '0;
         end
      end
      if (inflight_q) begin
         fifo_mem_d[fifo_wptr_q] = ram_rd_data;
      end
   end

   // State registers; reset discards all banks and buffered words at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_bank_q     <= 1'b0;
         rd_bank_q     <= 1'b0;
         wr_cnt_q      <= '0;
         rd_cnt_q      <= '0;
         bank_full_q   <= 2'b00;
         inflight_q    <= 1'b0;
         fifo_cnt_q    <= 2'd0;
         fifo_rptr_q   <= 1'b0;
         fifo_wptr_q   <= 1'b0;
         fifo_mem_q[0] <= '0;
         fifo_mem_q[1] <= '0;
      end else begin
         wr_bank_q     <= wr_bank_d;
         rd_bank_q     <= rd_bank_d;
         wr_cnt_q      <= wr_cnt_d;
         rd_cnt_q      <= rd_cnt_d;
         bank_full_q   <= bank_full_d;
         inflight_q    <= inflight_d;
         fifo_cnt_q    <= fifo_cnt_d;
         fifo_rptr_q   <= fifo_rptr_d;
         fifo_wptr_q   <= fifo_wptr_d;
         fifo_mem_q[0] <= fifo_mem_d[0];
         fifo_mem_q[1] <= fifo_mem_d[1];
      end
   end

   // A bank can only be set while empty and cleared while full.
   a_no_set_clr_same_bank: assert property (@(posedge clk) disable iff (!rst_n)
      (set_full & clr_full) == 2'b00);

`ifdef PINGPONG_STATUS_EN
   logic [15:0] swap_cnt_q, swap_cnt_d;

   assign swap_cnt_d = (clr_full != 2'b00) ? swap_cnt_q + 16'd1 : swap_cnt_q;

   // Release counter, wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) swap_cnt_q <= 16'd0;
      else        swap_cnt_q <= swap_cnt_d;
   end

   assign bank_full = bank_full_q;
   assign swap_cnt  = swap_cnt_q;
`endif

endmodule

// File: tb/tb_pingpong_ram_ctrl.sv
// Bench for pingpong_ram_ctrl: behavioural byte-queue scoreboard plus a
// big-endian width-converting RAM model. Build with PINGPONG_STATUS_EN to
// also cover the status ports.
module tb_pingpong_ram_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        s_valid, s_ready, m_valid, m_ready;
   logic [7:0]  s_data;
   logic [15:0] m_data;
   logic        ram_wr_en;
   logic [6:0]  ram_wr_addr;
   logic [7:0]  ram_wr_data;
   logic [5:0]  ram_rd_addr;
   logic [15:0] ram_rd_data;
`ifdef PINGPONG_STATUS_EN
   logic [1:0]  bank_full;
   logic [15:0] swap_cnt;
`endif

   always #5 clk = ~clk;

   pingpong_ram_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
      .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
`ifdef PINGPONG_STATUS_EN
      , .bank_full(bank_full), .swap_cnt(swap_cnt)
`endif
   );

   // External RAM: byte-wide write port, 16-bit registered big-endian read.
   logic [7:0] mem [0:127];
   always @(posedge clk) begin
      if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
      ram_rd_data <= {mem[{ram_rd_addr, 1'b0}], mem[{ram_rd_addr, 1'b1}]};
   end

   int         n_cmp = 0;
   int         n_fail = 0;
   int         pops = 0;
   int         acc_total = 0;
   bit         rnd_ready = 0;
   logic [7:0] q [$];
   logic       stall_prev = 1'b0;
   logic [15:0] data_prev = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: accepted bytes queue up in order; every output word must be
   // the next two bytes, first byte in the high half. Write addresses follow
   // the running byte count modulo the RAM depth.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         acc_total  = 0;
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, data_prev);
         end
         if (s_valid && s_ready) begin
            chk("wr_en", ram_wr_en, 1);
            chk("wr_addr", ram_wr_addr, acc_total % 128);
            chk("wr_data", ram_wr_data, s_data);
            q.push_back(s_data);
            acc_total++;
         end else begin
            chk("wr_idle", ram_wr_en, 0);
         end
         if (m_valid && m_ready) begin
            chk("out_word", m_data, (q.size() >= 2) ? {16'h0, q[0], q[1]} : 32'hFFFF_FFFF);
            if (q.size() > 0) void'(q.pop_front());
            if (q.size() > 0) void'(q.pop_front());
            pops++;
         end
         stall_prev = m_valid && !m_ready;
         data_prev  = m_data;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic push(input logic [7:0] d, output int waits);
      waits   = 0;
      s_valid = 1'b1;
      s_data  = d;
      @(negedge clk);
      while (!s_ready && waits < 2000) begin
         cyc();
         waits++;
         @(negedge clk);
      end
      if (!s_ready) chk("push_timeout", s_ready, 1);
      cyc();
      s_valid = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while (q.size() != 0 && k < 4000) begin
         cyc();
         k++;
      end
      repeat (3) cyc();
      chk("drain_left", q.size(), 0);
   endtask

   task automatic do_reset();
      s_valid = 1'b0;
      rst_n   = 1'b0;
      #1;
      chk("rst_s_ready", s_ready, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_wr_en", ram_wr_en, 0);
      chk("rst_wr_addr", ram_wr_addr, 0);
      chk("rst_rd_addr", ram_rd_addr, 0);
`ifdef PINGPONG_STATUS_EN
      chk("rst_bank_full", bank_full, 0);
      chk("rst_swap_cnt", swap_cnt, 0);
`endif
      cyc();
      cyc();
      rst_n = 1'b1;
      pops  = 0;
   endtask

   initial begin
      int w, stalls, n;
      s_valid = 1'b0;
      s_data  = '0;
      m_ready = 1'b0;
      #2;
      do_reset();

      // Bytes 0x00..0x3F, output ready: 32 words, first one 2 edges after the fill.
      m_ready = 1'b1;
      for (int i = 0; i < 64; i++) push(8'(i), w);
      @(negedge clk); chk("lat_edge0", m_valid, 0);
      @(negedge clk); chk("lat_edge1", m_valid, 0);
      @(negedge clk); chk("lat_edge2", m_valid, 1);
      chk("first_word", m_data, 16'h0001);
      drain();
      chk("t1_words", pops, 32);
      chk("t1_rd_addr", ram_rd_addr, 32);

      // 256 bytes back to back: writer never stalls, 128 words in order.
      pops   = 0;
      stalls = 0;
      for (int i = 0; i < 256; i++) begin
         push(8'($urandom), w);
         stalls += w;
      end
      chk("t2_stalls", stalls, 0);
      drain();
      chk("t2_words", pops, 128);

      // Both banks filled with output blocked, then released by the reader.
      do_reset();
      m_ready = 1'b0;
      for (int i = 0; i < 128; i++) push(8'($urandom), w);
      cyc();
      cyc();
      chk("t3_full_sready", s_ready, 0);
      chk("t3_m_valid", m_valid, 1);
      chk("t3_head", m_data, {q[0], q[1]});
`ifdef PINGPONG_STATUS_EN
      chk("t3_bank_full", bank_full, 2'b11);
`endif
      m_ready = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!s_ready && n < 200);
      chk("t3_sready_return", n, 31);
      drain();
      chk("t3_words", pops, 64);

      // Random source gaps and random backpressure over 1024 bytes.
      pops      = 0;
      rnd_ready = 1;
      for (int i = 0; i < 1024; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) cyc();
         end
         push(8'($urandom), w);
      end
      drain();
      rnd_ready = 0;
      m_ready   = 1'b1;
      chk("t4_words", pops, 512);

      // Reset in the middle of the second bank while words are buffered.
      m_ready = 1'b0;
      for (int i = 0; i < 84; i++) push(8'($urandom), w);
      cyc();
      chk("t5_pre_m_valid", m_valid, 1);
      s_valid = 1'b1;
      s_data  = 8'hAA;
      rst_n   = 1'b0;
      #1;
      chk("t5_m_valid", m_valid, 0);
      chk("t5_s_ready", s_ready, 1);
      chk("t5_wr_en", ram_wr_en, 0);
      chk("t5_m_data", m_data, 0);
      cyc();
      chk("t5_wr_en_held", ram_wr_en, 0);
      s_valid = 1'b0;
      rst_n   = 1'b1;
      pops    = 0;
      m_ready = 1'b1;
      for (int i = 0; i < 64; i++) push(8'($urandom), w);
      drain();
      chk("t5_words", pops, 32);
      chk("t5_rd_addr", ram_rd_addr, 32);

      // Four full banks with the status flags tracked along the way.
      do_reset();
      m_ready = 1'b0;
      for (int i = 0; i < 64; i++) push(8'($urandom), w);
      cyc();
`ifdef PINGPONG_STATUS_EN
      chk("t6_flags_01", bank_full, 2'b01);
`endif
      for (int i = 0; i < 64; i++) push(8'($urandom), w);
      cyc();
      chk("t6_sready_low", s_ready, 0);
`ifdef PINGPONG_STATUS_EN
      chk("t6_flags_11", bank_full, 2'b11);
`endif
      m_ready = 1'b1;
`ifdef PINGPONG_STATUS_EN
      n = 0;
      while (bank_full == 2'b11 && n < 200) begin
         cyc();
         n++;
      end
      chk("t6_flags_10", bank_full, 2'b10);
`endif
      for (int i = 0; i < 128; i++) push(8'($urandom), w);
      drain();
      chk("t6_words", pops, 128);
      chk("t6_rd_addr", ram_rd_addr, 0);
`ifdef PINGPONG_STATUS_EN
      chk("t6_swap_cnt", swap_cnt, 4);
      chk("t6_flags_00", bank_full, 2'b00);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
